// File: rtl/rst_seq_if.sv
// rst_seq_if: zero-wait register bus into rst_seq.
// Master drives stb/we/addr/data_in; slave returns data_out/ack.
interface rst_seq_if;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (
    output stb, we, addr, data_in,
    input  data_out, ack
  );

  modport slave (
    input  stb, we, addr, data_in,
    output data_out, ack
  );
endinterface

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer with cause capture and hold timer.
// Ports: clk, rst (sync, active-high), bus (rst_seq_if.slave:
// CTRL addr 0, CAUSE addr 1), sys_rst_req, wdog_req, btn_in (async),
// rst_out. Define RST_SEQ_DEBOUNCE_EN to debounce the button.
module rst_seq #(
  parameter int HOLD_CYCLES   = 16,
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic     clk,
  input  logic     rst,
  rst_seq_if.slave bus,
  input  logic     sys_rst_req,
  input  logic     wdog_req,
  input  logic     btn_in,
  output logic     rst_out
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_CLR
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  last_q;
  logic [3:0]  sticky_q;
  logic [15:0] count_q;

  logic        btn_s1, btn_s2;
  logic        btn_evt;
  logic        wr_ctrl, wr_cause, rd;
  logic        sw_req;
  logic [3:0]  src;
  logic        capture;
  logic [3:0]  sticky_kept;
  logic        unused_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
    end
  end

`ifdef RST_SEQ_DEBOUNCE_EN
  // Counter parks at all-ones once fired; only a release re-arms.
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic                     db_fired;

  assign btn_evt = btn_s2 && !db_fired && (&db_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      db_fired <= 1'b0;
    end else if (!btn_s2) begin
      db_cnt   <= '0;
      db_fired <= 1'b0;
    end else if (btn_evt) begin
      db_fired <= 1'b1;
    end else if (!db_fired) begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign unused_ok = ^bus.data_in[31:4];
`else
  logic btn_d;

  always_ff @(posedge clk) begin
    if (rst) btn_d <= 1'b0;
    else     btn_d <= btn_s2;
  end

  assign btn_evt   = btn_s2 & ~btn_d;
  assign unused_ok = ^{bus.data_in[31:4], DEBOUNCE_BITS != 0};
`endif

  assign wr_ctrl  = bus.stb & bus.we & ~bus.addr;
  assign wr_cause = bus.stb & bus.we & bus.addr;
  assign rd       = bus.stb & ~bus.we;
  assign sw_req   = wr_ctrl & bus.data_in[0];

  assign src     = {btn_evt, wdog_req, sys_rst_req, sw_req};
  assign capture = (state_q == IDLE) && (|src);

  // W1C first, then any new capture ORs back in so capture wins.
  assign sticky_kept =
    wr_cause ? (sticky_q & ~bus.data_in[3:0]) : sticky_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|src) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) state_d = WAIT_CLR;
        else                     hold_d  = hold_q + 16'd1;
      end
      WAIT_CLR: begin
        if (!sys_rst_req && !wdog_req && !btn_s2)
          state_d = IDLE;
      end
      default: begin
        state_d = HOLD;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_kept | (capture ? src : 4'h0);
      if (capture) begin
        last_q <= src;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
    end
  end

  assign rst_out = (state_q == HOLD);
  assign bus.ack = bus.stb;

  always_comb begin
    bus.data_out = '0;
    unique case (1'b1)
      rd && !bus.addr:
        bus.data_out = {count_q, 12'h000, last_q};
      rd && bus.addr:
        bus.data_out = {28'h0, sticky_q};
      default: ;
    endcase
  end

endmodule
